// File: rtl/hps_io_pkg.sv
// Shared command codes, FSM states and index width
// for the HPS io command dispatcher.
package hps_io_pkg;

  localparam int IDX_W = 8;
  localparam int WORD_W = 16;

  localparam logic [15:0] GET_ID     = 16'h0001;
  localparam logic [15:0] SET_STATUS = 16'h001E;
  localparam logic [15:0] GET_STATUS = 16'h0014;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LOCAL,
    FWD,
    OSD
  } state_t;

  function automatic logic is_local(
    input logic [15:0] code
  );
    return code == GET_ID ||
           code == SET_STATUS ||
           code == GET_STATUS;
  endfunction

endpackage

// File: rtl/hps_io_dispatch_if.sv
// SPI word-side bundle: io_strobe, io_din, io_enable,
// osd_enable from the HPS side; io_dout back to it.
interface hps_io_dispatch_if;
  import hps_io_pkg::*;

  logic              io_strobe;
  logic [WORD_W-1:0] io_din;
  logic              io_enable;
  logic              osd_enable;
  logic [WORD_W-1:0] io_dout;

  modport master (
    output io_strobe, io_din,
    output io_enable, osd_enable,
    input  io_dout
  );

  modport slave (
    input  io_strobe, io_din,
    input  io_enable, osd_enable,
    output io_dout
  );

endinterface

// File: rtl/hps_io_wdog.sv
// Transaction watchdog: counts while run is high, kick clears,
// expire pulses on the TIMEOUT-th idle cycle. Ports: clk, reset, run, kick, expire.
module hps_io_wdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expire = run && !kick &&
                  (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || !run || kick) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hps_io_dispatch.sv
// HPS io command sequencer: spi (slave) word port, status reg,
// ext_* handler port, osd_wr, err. Optional watchdog: HPS_IO_WDOG_EN.
module hps_io_dispatch
  import hps_io_pkg::*;
#(
  parameter logic [15:0] CORE_ID     = 16'h0000,
  parameter logic [31:0] STATUS_INIT = 32'h0,
  parameter int          TIMEOUT     = 4096
) (
  input  logic             sys_clk,
  input  logic             reset,
  hps_io_dispatch_if.slave spi,
  output logic [31:0]      status,
  output logic             status_upd,
  output logic [15:0]      ext_cmd,
  output logic [IDX_W-1:0] ext_idx,
  output logic [15:0]      ext_data,
  output logic             ext_wr,
  output logic             ext_end,
  input  logic [15:0]      ext_rd,
  output logic             osd_wr,
  output logic             err
);

  state_t           state;
  logic             osd_q;
  logic [IDX_W-1:0] cnt;
  logic [15:0]      lo;
  logic             pend;
  logic             pend_fwd;
  logic [15:0]      pend_val;
  logic             wd_block;
  logic             wd_expire;
  logic [15:0]      cmd_ret;
  logic [15:0]      pay_ret;
  logic [IDX_W-1:0] cnt_nx;

`ifdef HPS_IO_WDOG_EN
  hps_io_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (sys_clk),
    .reset  (reset),
    .run    (state != IDLE),
    .kick   (spi.io_strobe),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0 && (TIMEOUT > 0);
`endif

  assign cnt_nx = (&cnt) ? cnt : cnt + 1'b1;

  // Return word for the command word itself.
  always_comb begin
    cmd_ret = '0;
    unique case (1'b1)
      spi.io_din == GET_ID:     cmd_ret = CORE_ID;
      spi.io_din == GET_STATUS: cmd_ret = status[15:0];
      default:                  cmd_ret = '0;
    endcase
  end

  // Return word for a built-in payload word.
  always_comb begin
    pay_ret = '0;
    if (ext_cmd == GET_STATUS && cnt == 1)
      pay_ret = status[31:16];
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      osd_q       <= 1'b0;
      cnt         <= '0;
      lo          <= '0;
      pend        <= 1'b0;
      pend_fwd    <= 1'b0;
      pend_val    <= '0;
      wd_block    <= 1'b0;
      spi.io_dout <= '0;
      status      <= STATUS_INIT;
      status_upd  <= 1'b0;
      ext_cmd     <= '0;
      ext_idx     <= '0;
      ext_data    <= '0;
      ext_wr      <= 1'b0;
      ext_end     <= 1'b0;
      osd_wr      <= 1'b0;
      err         <= 1'b0;
    end else begin
      status_upd <= 1'b0;
      ext_wr     <= 1'b0;
      ext_end    <= 1'b0;
      osd_wr     <= 1'b0;
      pend       <= 1'b0;
      pend_fwd   <= 1'b0;
      osd_q      <= spi.osd_enable;

      // Second pipeline stage: io_dout lands at strobe+2.
      if (pend)
        spi.io_dout <= pend_fwd ? ext_rd : pend_val;

      if (!spi.io_enable && !spi.osd_enable)
        wd_block <= 1'b0;

      if (state inside {CMD, LOCAL, FWD} &&
          spi.osd_enable && !osd_q)
        err <= 1'b1;

      if (wd_expire) begin
        state    <= IDLE;
        wd_block <= 1'b1;
        err      <= 1'b1;
        if (state == FWD) ext_end <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (spi.io_strobe) err <= 1'b1;
            if (!wd_block) begin
              if (spi.io_enable) begin
                state <= CMD;
                if (spi.osd_enable) err <= 1'b1;
              end else if (spi.osd_enable) begin
                state <= OSD;
              end
            end
          end
          CMD: begin
            if (spi.io_strobe) begin
              ext_cmd  <= spi.io_din;
              ext_idx  <= 8'd1;
              cnt      <= 8'd1;
              pend     <= 1'b1;
              pend_val <= cmd_ret;
              state    <= is_local(spi.io_din) ? LOCAL : FWD;
            end else if (!spi.io_enable) begin
              state <= IDLE;
            end
          end
          LOCAL: begin
            if (spi.io_strobe) begin
              ext_idx  <= cnt;
              cnt      <= cnt_nx;
              pend     <= 1'b1;
              pend_val <= pay_ret;
              if (ext_cmd == SET_STATUS) begin
                if (cnt == 1) lo <= spi.io_din;
                if (cnt == 2) begin
                  status     <= {spi.io_din, lo};
                  status_upd <= 1'b1;
                end
              end
            end else if (!spi.io_enable) begin
              state <= IDLE;
            end
          end
          FWD: begin
            if (spi.io_strobe) begin
              ext_wr   <= 1'b1;
              ext_data <= spi.io_din;
              ext_idx  <= cnt;
              cnt      <= cnt_nx;
              pend     <= 1'b1;
              pend_fwd <= 1'b1;
            end else if (!spi.io_enable) begin
              state   <= IDLE;
              ext_end <= 1'b1;
            end
          end
          OSD: begin
            if (spi.io_strobe) begin
              osd_wr   <= 1'b1;
              ext_data <= spi.io_din;
              pend     <= 1'b1;
              pend_val <= '0;
            end else if (!spi.osd_enable) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hps_io_dispatch.sv
// Directed bench for hps_io_dispatch: built-in commands,
// forwarding, OSD, error cases, reset abort, optional watchdog.
module tb_hps_io_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] status;
  logic        status_upd;
  logic [15:0] ext_cmd;
  logic [7:0]  ext_idx;
  logic [15:0] ext_data;
  logic        ext_wr;
  logic        ext_end;
  logic [15:0] ext_rd;
  logic        osd_wr;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;
  int n_upd    = 0;
  int n_wr     = 0;
  int n_end    = 0;
  int n_osd    = 0;

  hps_io_dispatch_if spi ();

  hps_io_dispatch #(
    .CORE_ID     (16'hC0DE),
    .STATUS_INIT (32'h0000_00A5),
    .TIMEOUT     (16)
  ) dut (
    .sys_clk    (clk),
    .reset      (reset),
    .spi        (spi),
    .status     (status),
    .status_upd (status_upd),
    .ext_cmd    (ext_cmd),
    .ext_idx    (ext_idx),
    .ext_data   (ext_data),
    .ext_wr     (ext_wr),
    .ext_end    (ext_end),
    .ext_rd     (ext_rd),
    .osd_wr     (osd_wr),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Handler model: return word is twice the payload index.
  assign ext_rd = {7'd0, ext_idx, 1'b0};

  always @(negedge clk) begin
    if (status_upd) n_upd++;
    if (ext_wr)     n_wr++;
    if (ext_end)    n_end++;
    if (osd_wr)     n_osd++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at strobe+1.
  task automatic send(input logic [15:0] w);
    spi.io_strobe = 1'b1;
    spi.io_din    = w;
    step(1);
    spi.io_strobe = 1'b0;
    spi.io_din    = '0;
  endtask

  initial begin
    int k;
    reset          = 1'b1;
    spi.io_strobe  = 1'b0;
    spi.io_din     = '0;
    spi.io_enable  = 1'b0;
    spi.osd_enable = 1'b0;
    step(3);
    chk("rst_dout", 32'(spi.io_dout), 32'h0);
    chk("rst_status", status, 32'h0000_00A5);
    chk("rst_cmd", 32'(ext_cmd), 32'h0);
    chk("rst_idx", 32'(ext_idx), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_pulses",
        32'({status_upd, ext_wr, ext_end, osd_wr}), 32'h0);
    reset = 1'b0;
    step(1);

    // GET_ID
    spi.io_enable = 1'b1;
    step(1);
    send(16'h0001);
    chk("id_cmd", 32'(ext_cmd), 32'h0001);
    chk("id_idx", 32'(ext_idx), 32'h1);
    step(1);
    chk("id_dout", 32'(spi.io_dout), 32'hC0DE);
    send(16'hFFFF);
    chk("id_hold", 32'(spi.io_dout), 32'hC0DE);
    step(1);
    chk("id_tail", 32'(spi.io_dout), 32'h0);
    spi.io_enable = 1'b0;
    step(2);

    // SET_STATUS 0x12345678
    spi.io_enable = 1'b1;
    step(1);
    send(16'h001E);
    step(1);
    send(16'h5678);
    chk("set_half", status, 32'h0000_00A5);
    step(1);
    send(16'h1234);
    chk("set_status", status, 32'h1234_5678);
    chk("set_upd", 32'(status_upd), 32'h1);
    step(1);
    spi.io_enable = 1'b0;
    step(2);
    chk("set_upd_cnt", 32'(n_upd), 32'd1);

    // GET_STATUS
    spi.io_enable = 1'b1;
    step(1);
    send(16'h0014);
    step(1);
    chk("get_lo", 32'(spi.io_dout), 32'h5678);
    send(16'h0000);
    step(1);
    chk("get_hi", 32'(spi.io_dout), 32'h1234);
    send(16'h0000);
    step(1);
    chk("get_tail", 32'(spi.io_dout), 32'h0);
    spi.io_enable = 1'b0;
    step(2);

    // Partial SET_STATUS leaves status alone
    spi.io_enable = 1'b1;
    step(1);
    send(16'h001E);
    step(1);
    send(16'hAAAA);
    spi.io_enable = 1'b0;
    step(3);
    chk("part_status", status, 32'h1234_5678);
    chk("part_upd", 32'(n_upd), 32'd1);

    // Forwarded command 0x0030
    spi.io_enable = 1'b1;
    step(1);
    send(16'h0030);
    step(1);
    chk("fwd_cmd_ret", 32'(spi.io_dout), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      send(16'h00A0 + 16'(i));
      chk("fwd_wr", 32'(ext_wr), 32'h1);
      chk("fwd_idx", 32'(ext_idx), 32'(i));
      chk("fwd_data", 32'(ext_data), 32'h00A0 + 32'(i));
      step(1);
      chk("fwd_dout", 32'(spi.io_dout), 32'(2 * i));
    end
    chk("fwd_no_end", 32'(n_end), 32'd0);
    spi.io_enable = 1'b0;
    step(1);
    chk("fwd_end", 32'(ext_end), 32'h1);
    step(2);
    chk("fwd_end_cnt", 32'(n_end), 32'd1);
    chk("fwd_wr_cnt", 32'(n_wr), 32'd3);
    chk("fwd_err", 32'(err), 32'h0);

    // OSD
    spi.osd_enable = 1'b1;
    step(1);
    send(16'h1111);
    chk("osd_wr", 32'(osd_wr), 32'h1);
    chk("osd_data", 32'(ext_data), 32'h1111);
    step(1);
    chk("osd_dout", 32'(spi.io_dout), 32'h0);
    send(16'h2222);
    step(1);
    spi.osd_enable = 1'b0;
    step(2);
    chk("osd_cnt", 32'(n_osd), 32'd2);
    chk("osd_no_ext", 32'(n_wr), 32'd3);
    chk("osd_err", 32'(err), 32'h0);

    // Both enables from IDLE: io wins, err set
    spi.io_enable  = 1'b1;
    spi.osd_enable = 1'b1;
    step(1);
    chk("both_err", 32'(err), 32'h1);
    send(16'h0001);
    step(1);
    chk("both_io", 32'(spi.io_dout), 32'hC0DE);
    chk("both_no_osd", 32'(n_osd), 32'd2);
    spi.io_enable  = 1'b0;
    spi.osd_enable = 1'b0;
    step(2);

    // Reset mid-FWD aborts without ext_end
    spi.io_enable = 1'b1;
    step(1);
    send(16'h0040);
    send(16'h0005);
    chk("abort_wr", 32'(ext_wr), 32'h1);
    step(1);
    chk("abort_dout", 32'(spi.io_dout), 32'h2);
    reset = 1'b1;
    step(1);
    spi.io_enable = 1'b0;
    chk("abort_dout0", 32'(spi.io_dout), 32'h0);
    chk("abort_cmd", 32'(ext_cmd), 32'h0);
    chk("abort_idx", 32'(ext_idx), 32'h0);
    chk("abort_data", 32'(ext_data), 32'h0);
    chk("abort_status", status, 32'h0000_00A5);
    chk("abort_err", 32'(err), 32'h0);
    reset = 1'b0;
    step(3);
    chk("abort_no_end", 32'(n_end), 32'd1);

`ifdef HPS_IO_WDOG_EN
    // Watchdog: FWD starved for 16 cycles
    spi.io_enable = 1'b1;
    step(1);
    send(16'h0030);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      step(1);
      if (ext_end) k = i;
    end
    chk("wd_cycles", 32'(k), 32'd16);
    chk("wd_err", 32'(err), 32'h1);
    chk("wd_end_cnt", 32'(n_end), 32'd2);
    step(2);
    send(16'h0001);
    step(1);
    chk("wd_blocked", 32'(spi.io_dout), 32'h0);
    spi.io_enable = 1'b0;
    step(3);
    chk("wd_end_once", 32'(n_end), 32'd2);
`else
    k = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
